// File: rtl/fiber_pkg.sv
// fiber_pkg: types and defaults shared by the fiberBank DRAM adapter.
//   - FIBER_DW / FIBER_AW : default fill word and byte address widths
//   - fiber_state_e       : adapter FSM states
//   - fiber_req_e         : kind of memory-side activity the adapter is performing
package fiber_pkg;

  localparam int unsigned FIBER_DW = 16;
  localparam int unsigned FIBER_AW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StRdReq,
    StRdWait,
    StRdRsp
  } fiber_state_e;

  typedef enum logic [1:0] {
    ReqFetch,
    ReqRead,
    ReqWrite,
    ReqConsume
  } fiber_req_e;

  function automatic logic req_is_write(input fiber_req_e req);
    return req == ReqWrite;
  endfunction

endpackage

// File: rtl/fiber_sat_counter.sv
// fiber_sat_counter: up/down counter that sticks at all-ones and at zero.
//   i_clk, i_reset : clock, synchronous active-high reset (clears to 0)
//   i_inc, i_dec   : step requests; both together leave the count unchanged
//   o_count        : current count
module fiber_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fiber_dram_adapter.sv
// fiber_dram_adapter: bridges one fiberBank DRAM crossbar port to an in-order memory
// req/rsp channel, one transaction in flight at a time.
//   Bank side  : i_bank_addr, i_bank_fill_wait, o_bank_data(_valid),
//                i_bank_wb_data/valid, o_bank_wb_ready
//   Memory side: o_mem_req_valid/we/addr/wdata, i_mem_req_ready,
//                i_mem_rsp_valid/data, o_mem_rsp_ready
//   Status     : o_err (sticky read failure), o_fill_cnt, o_wb_cnt (saturating)
// Reads that time out are reissued; responses to abandoned reads ("orphans") are
// counted and silently dropped when they eventually arrive.
module fiber_dram_adapter
  import fiber_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = FIBER_DW,
  parameter int unsigned ADDR_WIDTH  = FIBER_AW,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned MAX_RETRY   = 2,
  parameter int unsigned ORPHAN_BITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_bank_addr,
  input  logic                  i_bank_fill_wait,
  output logic [DATA_WIDTH-1:0] o_bank_data,
  output logic                  o_bank_data_valid,
  input  logic [DATA_WIDTH-1:0] i_bank_wb_data,
  input  logic                  i_bank_wb_valid,
  output logic                  o_bank_wb_ready,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_we,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
  input  logic                  i_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_rsp_data,
  output logic                  o_mem_rsp_ready,
  output logic                  o_err,
  output logic [31:0]           o_fill_cnt,
  output logic [31:0]           o_wb_cnt
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

  fiber_state_e          r_state,  w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,  w_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_rdata,  w_rdata_nxt;
  logic [RETRY_W-1:0]    r_retry,  w_retry_nxt;
  logic [TMO_W-1:0]      r_tmo,    w_tmo_nxt;
  logic                  r_err,    w_err_nxt;

  logic [TMO_W-1:0]       w_tmo_sum;
  logic [ORPHAN_BITS-1:0] w_orph_cnt;
  logic                   w_orph_nz;
  logic                   w_orph_inc, w_orph_dec;
  logic                   w_fill_inc, w_wb_inc;
  logic                   w_wb_ready, w_data_valid, w_req_valid, w_rsp_ready;
  fiber_req_e             w_req;

  assign w_tmo_sum = r_tmo + TMO_W'(1);
  assign w_orph_nz = |w_orph_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_retry <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_retry <= w_retry_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    w_retry_nxt  = r_retry;
    w_tmo_nxt    = r_tmo;
    w_err_nxt    = r_err;
    w_wb_inc     = 1'b0;
    w_fill_inc   = 1'b0;
    w_orph_inc   = 1'b0;
    // A response arriving while orphans are outstanding belongs to an abandoned read.
    w_orph_dec   = i_mem_rsp_valid & w_orph_nz;
    w_rsp_ready  = w_orph_nz;
    w_wb_ready   = 1'b0;
    w_data_valid = 1'b0;
    w_req_valid  = 1'b0;
    w_req        = ReqFetch;

    unique case (r_state)
      StIdle: begin
        if (i_bank_wb_valid) begin
          w_wb_ready  = 1'b1;
          w_addr_nxt  = i_bank_addr;
          w_wdata_nxt = i_bank_wb_data;
          w_state_nxt = StWbReq;
        end else if (i_bank_fill_wait) begin
          w_addr_nxt  = i_bank_addr;
          w_retry_nxt = '0;
          w_state_nxt = StRdReq;
        end
      end
      StWbReq: begin
        w_req_valid = 1'b1;
        w_req       = ReqWrite;
        if (i_mem_req_ready) begin
          w_wb_inc    = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StRdReq: begin
        w_req_valid = 1'b1;
        w_req       = ReqRead;
        if (i_mem_req_ready) begin
          w_tmo_nxt   = '0;
          w_state_nxt = StRdWait;
        end
      end
      StRdWait: begin
        w_rsp_ready = 1'b1;
        w_tmo_nxt   = w_tmo_sum;
        if (i_mem_rsp_valid && !w_orph_nz) begin
          // A live response beats a timeout landing in the same cycle.
          w_rdata_nxt = i_mem_rsp_data;
          w_state_nxt = StRdRsp;
        end else if (w_tmo_sum == TMO_W'(TIMEOUT_CYC)) begin
          w_orph_inc = 1'b1;
          if (r_retry < RETRY_W'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RETRY_W'(1);
            w_state_nxt = StRdReq;
          end else begin
            w_err_nxt   = 1'b1;
            w_rdata_nxt = '0;
            w_state_nxt = StRdRsp;
          end
        end
      end
      StRdRsp: begin
        w_data_valid = 1'b1;
        w_req        = ReqConsume;
        if (i_bank_fill_wait) begin
          w_fill_inc  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  fiber_sat_counter #(.WIDTH(32)) u_fill_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_fill_inc),
    .i_dec   (1'b0),
    .o_count (o_fill_cnt)
  );

  fiber_sat_counter #(.WIDTH(32)) u_wb_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_wb_inc),
    .i_dec   (1'b0),
    .o_count (o_wb_cnt)
  );

  fiber_sat_counter #(.WIDTH(ORPHAN_BITS)) u_orphan_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_orph_inc),
    .i_dec   (w_orph_dec),
    .o_count (w_orph_cnt)
  );

  // Handshake outputs are held low while reset is asserted, whatever the inputs do.
  assign o_bank_wb_ready   = w_wb_ready   & ~i_reset;
  assign o_bank_data_valid = w_data_valid & ~i_reset;
  assign o_mem_req_valid   = w_req_valid  & ~i_reset;
  assign o_mem_rsp_ready   = w_rsp_ready  & ~i_reset;
  assign o_mem_req_we      = req_is_write(w_req) & ~i_reset;
  assign o_mem_req_addr    = r_addr;
  assign o_mem_req_wdata   = r_wdata;
  assign o_bank_data       = r_rdata;
  assign o_err             = r_err;

endmodule

// File: tb/tb_fiber_dram_adapter.sv
// tb_fiber_dram_adapter: directed and randomized transactions against a transaction-level
// model (expected request stream, expected fill word, expected counter values).
module tb_fiber_dram_adapter;

  localparam int unsigned DW      = 16;
  localparam int unsigned AW      = 64;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned RETRIES = 2;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [AW-1:0] i_bank_addr;
  logic          i_bank_fill_wait;
  logic [DW-1:0] o_bank_data;
  logic          o_bank_data_valid;
  logic [DW-1:0] i_bank_wb_data;
  logic          i_bank_wb_valid;
  logic          o_bank_wb_ready;
  logic          o_mem_req_valid;
  logic          i_mem_req_ready;
  logic          o_mem_req_we;
  logic [AW-1:0] o_mem_req_addr;
  logic [DW-1:0] o_mem_req_wdata;
  logic          i_mem_rsp_valid;
  logic [DW-1:0] i_mem_rsp_data;
  logic          o_mem_rsp_ready;
  logic          o_err;
  logic [31:0]   o_fill_cnt;
  logic [31:0]   o_wb_cnt;

  fiber_dram_adapter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .TIMEOUT_CYC (TIMEOUT),
    .MAX_RETRY   (RETRIES),
    .ORPHAN_BITS (3)
  ) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_bank_addr       (i_bank_addr),
    .i_bank_fill_wait  (i_bank_fill_wait),
    .o_bank_data       (o_bank_data),
    .o_bank_data_valid (o_bank_data_valid),
    .i_bank_wb_data    (i_bank_wb_data),
    .i_bank_wb_valid   (i_bank_wb_valid),
    .o_bank_wb_ready   (o_bank_wb_ready),
    .o_mem_req_valid   (o_mem_req_valid),
    .i_mem_req_ready   (i_mem_req_ready),
    .o_mem_req_we      (o_mem_req_we),
    .o_mem_req_addr    (o_mem_req_addr),
    .o_mem_req_wdata   (o_mem_req_wdata),
    .i_mem_rsp_valid   (i_mem_rsp_valid),
    .i_mem_rsp_data    (i_mem_rsp_data),
    .o_mem_rsp_ready   (o_mem_rsp_ready),
    .o_err             (o_err),
    .o_fill_cnt        (o_fill_cnt),
    .o_wb_cnt          (o_wb_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_fill = 0;
  int exp_wb   = 0;

  // Accepted memory requests, recorded half a cycle before the accepting edge.
  logic          req_we_q[$];
  logic [AW-1:0] req_addr_q[$];
  logic [DW-1:0] req_data_q[$];

  always @(negedge i_clk) begin
    if (!i_reset && o_mem_req_valid && i_mem_req_ready) begin
      req_we_q.push_back(o_mem_req_we);
      req_addr_q.push_back(o_mem_req_addr);
      req_data_q.push_back(o_mem_req_wdata);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1 ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic get_req(input int bound, output logic we, output logic [AW-1:0] addr,
                         output logic [DW-1:0] data);
    int n = 0;
    while (req_we_q.size() == 0 && n < bound) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    chk("req_seen", 64'(req_we_q.size() != 0), 64'd1);
    if (req_we_q.size() != 0) begin
      we   = req_we_q.pop_front();
      addr = req_addr_q.pop_front();
      data = req_data_q.pop_front();
    end else begin
      we   = 1'b0;
      addr = '0;
      data = '0;
    end
  endtask

  task automatic send_rsp(input logic [DW-1:0] data);
    int n = 0;
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = data;
    @(negedge i_clk);
    while (!o_mem_rsp_ready && n < 80) begin
      @(negedge i_clk);
      n++;
    end
    chk("rsp_taken", 64'(o_mem_rsp_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    @(negedge i_clk);
    while (!o_bank_data_valid && n < bound) begin
      @(negedge i_clk);
      n++;
    end
    chk("fill_valid", 64'(o_bank_data_valid), 64'd1);
  endtask

  task automatic do_fill(input logic [AW-1:0] addr, input int req_dly, input int rsp_dly,
                         input logic [DW-1:0] word, input int stall);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            bad = 0;
    i_bank_addr      = addr;
    i_bank_fill_wait = 1'b1;
    i_mem_req_ready  = (req_dly == 0);
    @(posedge i_clk);
    #1;
    i_bank_addr = {$urandom, $urandom};
    repeat (req_dly) begin
      @(posedge i_clk);
      #1;
    end
    i_mem_req_ready = 1'b1;
    get_req(100, we, a, d);
    chk("fill_req_we", 64'(we), 64'd0);
    chk("fill_req_addr", a, addr);
    if (stall > 0) i_bank_fill_wait = 1'b0;
    repeat (rsp_dly) begin
      @(posedge i_clk);
      #1;
    end
    send_rsp(word);
    wait_valid(100);
    chk("fill_data", 64'(o_bank_data), 64'(word));
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge i_clk);
        if (!o_bank_data_valid || o_bank_data !== word) bad++;
      end
      chk("stall_hold", 64'(bad), 64'd0);
      @(posedge i_clk);
      #1;
      i_bank_fill_wait = 1'b1;
    end
    @(posedge i_clk);
    #1;
    i_bank_fill_wait = 1'b0;
    exp_fill++;
    chk("fill_cnt", 64'(o_fill_cnt), 64'(exp_fill));
    chk("fill_done_valid", 64'(o_bank_data_valid), 64'd0);
  endtask

  task automatic do_wb(input logic [AW-1:0] addr, input logic [DW-1:0] word, input int req_dly);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    i_bank_addr     = addr;
    i_bank_wb_data  = word;
    i_bank_wb_valid = 1'b1;
    i_mem_req_ready = (req_dly == 0);
    @(negedge i_clk);
    chk("wb_ready", 64'(o_bank_wb_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_bank_wb_valid = 1'b0;
    i_bank_addr     = {$urandom, $urandom};
    i_bank_wb_data  = DW'($urandom);
    repeat (req_dly) begin
      @(posedge i_clk);
      #1;
    end
    i_mem_req_ready = 1'b1;
    get_req(100, we, a, d);
    chk("wb_req_we", 64'(we), 64'd1);
    chk("wb_req_addr", a, addr);
    chk("wb_req_data", 64'(d), 64'(word));
    exp_wb++;
    chk("wb_cnt", 64'(o_wb_cnt), 64'(exp_wb));
  endtask

  initial begin
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] word;
    int            n;

    i_reset          = 1'b1;
    i_bank_addr      = '0;
    i_bank_fill_wait = 1'b0;
    i_bank_wb_data   = '0;
    i_bank_wb_valid  = 1'b0;
    i_mem_req_ready  = 1'b0;
    i_mem_rsp_valid  = 1'b0;
    i_mem_rsp_data   = '0;

    // Reset held for three edges; outputs checked while still in reset.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_data_valid", 64'(o_bank_data_valid), 64'd0);
    chk("rst_wb_ready", 64'(o_bank_wb_ready), 64'd0);
    chk("rst_req_valid", 64'(o_mem_req_valid), 64'd0);
    chk("rst_req_we", 64'(o_mem_req_we), 64'd0);
    chk("rst_rsp_ready", 64'(o_mem_rsp_ready), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_fill_cnt", 64'(o_fill_cnt), 64'd0);
    chk("rst_wb_cnt", 64'(o_wb_cnt), 64'd0);
    chk("rst_bank_data", 64'(o_bank_data), 64'd0);
    chk("rst_req_addr", o_mem_req_addr, 64'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("idle_req_valid", 64'(o_mem_req_valid), 64'd0);
    @(posedge i_clk);
    #1;

    // Clean fill.
    do_fill(64'h0000_0000_FFFF_FFFF, 0, 2, 16'hA5A5, 0);

    // Writeback and fill requested together: write goes out first.
    i_bank_addr      = 64'h0000_1234_5678_9ABC;
    i_bank_wb_data   = 16'h1234;
    i_bank_wb_valid  = 1'b1;
    i_bank_fill_wait = 1'b1;
    i_mem_req_ready  = 1'b1;
    @(negedge i_clk);
    chk("both_wb_ready", 64'(o_bank_wb_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_bank_wb_valid = 1'b0;
    get_req(100, we, a, d);
    chk("both_first_we", 64'(we), 64'd1);
    chk("both_first_data", 64'(d), 64'h1234);
    get_req(100, we, a, d);
    chk("both_second_we", 64'(we), 64'd0);
    chk("both_second_addr", a, 64'h0000_1234_5678_9ABC);
    send_rsp(16'h7E57);
    wait_valid(100);
    chk("both_fill_data", 64'(o_bank_data), 64'h7E57);
    @(posedge i_clk);
    #1;
    i_bank_fill_wait = 1'b0;
    exp_wb++;
    exp_fill++;
    chk("both_wb_cnt", 64'(o_wb_cnt), 64'(exp_wb));
    chk("both_fill_cnt", 64'(o_fill_cnt), 64'(exp_fill));

    // Randomized mix of writebacks and fills.
    for (int i = 0; i < 16; i++) begin
      a    = {$urandom, $urandom};
      word = DW'($urandom);
      if ($urandom_range(1, 0) == 1) do_wb(a, word, $urandom_range(3, 0));
      else do_fill(a, $urandom_range(3, 0), $urandom_range(8, 0), word, $urandom_range(3, 0));
    end

    // One timeout: the read is reissued after TIMEOUT cycles of silence,
    // the late answer to the first read is dropped, the second answer is delivered.
    i_bank_addr      = 64'hDEAD_0000_0000_0040;
    i_bank_fill_wait = 1'b1;
    i_mem_req_ready  = 1'b1;
    get_req(100, we, a, d);
    chk("tmo_first_we", 64'(we), 64'd0);
    n = 0;
    while (req_we_q.size() == 0 && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    // TIMEOUT silent cycles in the wait state, then one cycle presenting the reissue.
    chk("tmo_reissue_delay", 64'(n), 64'(TIMEOUT + 1));
    get_req(10, we, a, d);
    chk("tmo_reissue_we", 64'(we), 64'd0);
    chk("tmo_reissue_addr", a, 64'hDEAD_0000_0000_0040);
    send_rsp(16'hBEEF);
    send_rsp(16'h0F0F);
    wait_valid(100);
    chk("tmo_fill_data", 64'(o_bank_data), 64'h0F0F);
    chk("tmo_err", 64'(o_err), 64'd0);
    @(posedge i_clk);
    #1;
    i_bank_fill_wait = 1'b0;
    exp_fill++;
    chk("tmo_fill_cnt", 64'(o_fill_cnt), 64'(exp_fill));

    // Memory never answers: 1 + RETRIES reads, then an error fill of zero.
    i_bank_addr      = 64'hBAD0_0000_0000_0080;
    i_bank_fill_wait = 1'b1;
    for (int r = 0; r < int'(RETRIES) + 1; r++) begin
      get_req(200, we, a, d);
      chk("dead_read_addr", a, 64'hBAD0_0000_0000_0080);
    end
    wait_valid(200);
    chk("dead_extra_reads", 64'(req_we_q.size()), 64'd0);
    chk("dead_err", 64'(o_err), 64'd1);
    chk("dead_data", 64'(o_bank_data), 64'd0);
    @(posedge i_clk);
    #1;
    i_bank_fill_wait = 1'b0;
    exp_fill++;
    chk("dead_fill_cnt", 64'(o_fill_cnt), 64'(exp_fill));
    @(negedge i_clk);
    chk("orphan_rsp_ready", 64'(o_mem_rsp_ready), 64'd1);
    @(posedge i_clk);
    #1;
    for (int r = 0; r < int'(RETRIES) + 1; r++) send_rsp(DW'($urandom));
    @(negedge i_clk);
    chk("orphan_drained", 64'(o_mem_rsp_ready), 64'd0);
    chk("err_sticky", 64'(o_err), 64'd1);
    @(posedge i_clk);
    #1;

    // Bank stalls the delivered word for ten cycles.
    do_fill(64'h0000_0000_0000_0100, 1, 1, 16'h5A3C, 10);

    // Reset pulsed with a read outstanding.
    i_bank_addr      = 64'h0000_0000_0000_0200;
    i_bank_fill_wait = 1'b1;
    get_req(100, we, a, d);
    i_reset          = 1'b1;
    i_bank_fill_wait = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst2_data_valid", 64'(o_bank_data_valid), 64'd0);
    chk("rst2_req_valid", 64'(o_mem_req_valid), 64'd0);
    chk("rst2_rsp_ready", 64'(o_mem_rsp_ready), 64'd0);
    chk("rst2_err", 64'(o_err), 64'd0);
    chk("rst2_fill_cnt", 64'(o_fill_cnt), 64'd0);
    @(posedge i_clk);
    #1;
    req_we_q.delete();
    req_addr_q.delete();
    req_data_q.delete();
    exp_fill = 0;
    exp_wb   = 0;
    do_fill(64'h0123_4567_89AB_CDEF, 0, 0, 16'hC0DE, 0);
    do_wb(64'hFEDC_BA98_7654_3210, 16'h4321, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
